// File: rtl/pito_uart_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pito_uart_loader_pkg                                                 |
// | Shared types and constants for the UART boot loader.                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package pito_uart_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CMD  = 3'd1,
      ST_ADDR = 3'd2,
      ST_LEN  = 3'd3,
      ST_DATA = 3'd4,
      ST_CSUM = 3'd5,
      ST_RESP = 3'd6
   } loader_state_e;

   localparam logic [7:0] LOADER_CMD_WIMEM = 8'h01;
   localparam logic [7:0] LOADER_CMD_WDMEM = 8'h02;
   localparam logic [7:0] LOADER_CMD_RUN   = 8'h03;
   localparam logic [7:0] LOADER_CMD_HALT  = 8'h04;
   localparam logic [7:0] LOADER_ACK       = 8'h06;
   localparam logic [7:0] LOADER_NACK      = 8'h15;

   // True when a byte address / word count pair cannot be written to a RAM of 2^aw words.
   function automatic logic range_bad(input logic [31:0] addr,
                                      input logic [15:0] len,
                                      input int unsigned aw);
      logic [32:0] lim;
      lim = 33'd1 << aw;
      return (addr[1:0] != 2'b00) ||
             (({3'b000, addr[31:2]} + {17'd0, len}) > lim);
   endfunction

endpackage
`default_nettype wire

// File: rtl/pito_loader_timeout.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pito_loader_timeout                                                  |
// | Reloadable down-counter that strobes once TIMEOUT_CYCLES idle        |
// | enabled cycles have elapsed since the last clear.                    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pito_loader_timeout #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] c_load_val = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= c_load_val;
      end else if (clear) begin
         r_count <= c_load_val;
      end else if (enable && (r_count != '0)) begin
         r_count <= r_count - CW'(1);
      end
   end

   // A clear in the same cycle always beats expiry.
   assign expired = enable && !clear && (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/pito_uart_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pito_uart_loader                                                     |
// | UART packet boot loader: programs imem/dmem, answers ACK/NACK and    |
// | releases the pito core on RUN.                                       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pito_uart_loader #(
   parameter int unsigned IMEM_ADDR_W    = 10,
   parameter int unsigned DMEM_ADDR_W    = 10,
   parameter int unsigned TIMEOUT_CYCLES = 1000000,
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   rx_valid,
   input  logic [7:0]             rx_data,
   output logic                   tx_valid,
   input  logic                   tx_ready,
   output logic [7:0]             tx_data,
   output logic                   imem_req,
   output logic                   imem_we,
   output logic [IMEM_ADDR_W-1:0] imem_addr,
   output logic [31:0]            imem_wdata,
   output logic [3:0]             imem_be,
   output logic                   dmem_req,
   output logic                   dmem_we,
   output logic [DMEM_ADDR_W-1:0] dmem_addr,
   output logic [31:0]            dmem_wdata,
   output logic [3:0]             dmem_be,
   output logic                   core_rst_n,
   output logic                   busy,
   output logic                   err_timeout
);

   import pito_uart_loader_pkg::*;

   localparam int unsigned WA_W = (IMEM_ADDR_W > DMEM_ADDR_W) ? IMEM_ADDR_W : DMEM_ADDR_W;

   loader_state_e   r_state;
   logic [7:0]      r_cmd;
   logic [31:0]     r_addr;
   logic [7:0]      r_len_lo;
   logic [15:0]     r_words_left;
   logic [WA_W-1:0] r_waddr;
   logic [23:0]     r_shift;
   logic [1:0]      r_byte_cnt;
   logic [7:0]      r_csum;
   logic            r_bad;
   logic            r_ack;

   logic            w_tmo_en;
   logic            w_tmo_clear;
   logic            w_expired;
   logic [15:0]     w_len;
   logic [31:0]     w_word;
   logic            w_is_dmem;

   assign w_tmo_en    = (r_state != ST_IDLE) && (r_state != ST_RESP);
   assign w_tmo_clear = rx_valid || !w_tmo_en;
   assign w_len       = {rx_data, r_len_lo};
   assign w_word      = {rx_data, r_shift};
   assign w_is_dmem   = (r_cmd == LOADER_CMD_WDMEM);
   assign busy        = (r_state != ST_IDLE);

   pito_loader_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (w_tmo_clear),
      .enable  (w_tmo_en),
      .expired (w_expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_cmd        <= 8'h00;
         r_addr       <= 32'h0;
         r_len_lo     <= 8'h00;
         r_words_left <= 16'h0;
         r_waddr      <= '0;
         r_shift      <= 24'h0;
         r_byte_cnt   <= 2'd0;
         r_csum       <= 8'h00;
         r_bad        <= 1'b0;
         r_ack        <= 1'b0;
         tx_valid     <= 1'b0;
         tx_data      <= 8'h00;
         imem_req     <= 1'b0;
         imem_we      <= 1'b0;
         imem_addr    <= '0;
         imem_wdata   <= 32'h0;
         imem_be      <= 4'h0;
         dmem_req     <= 1'b0;
         dmem_we      <= 1'b0;
         dmem_addr    <= '0;
         dmem_wdata   <= 32'h0;
         dmem_be      <= 4'h0;
         core_rst_n   <= 1'b0;
         err_timeout  <= 1'b0;
      end else begin
         // Write strobes live for exactly one cycle.
         imem_req <= 1'b0;
         imem_we  <= 1'b0;
         imem_be  <= 4'h0;
         dmem_req <= 1'b0;
         dmem_we  <= 1'b0;
         dmem_be  <= 4'h0;

         case (r_state)
            ST_IDLE: begin
               if (rx_valid && (rx_data == SYNC_BYTE)) begin
                  r_state     <= ST_CMD;
                  err_timeout <= 1'b0;
                  r_csum      <= 8'h00;
                  r_bad       <= 1'b0;
                  r_byte_cnt  <= 2'd0;
               end
            end

            ST_CMD: begin
               if (rx_valid) begin
                  r_csum     <= r_csum ^ rx_data;
                  r_cmd      <= rx_data;
                  r_byte_cnt <= 2'd0;
                  case (rx_data)
                     LOADER_CMD_WIMEM, LOADER_CMD_WDMEM: r_state <= ST_ADDR;
                     LOADER_CMD_RUN, LOADER_CMD_HALT:    r_state <= ST_CSUM;
                     default: begin
                        tx_data  <= LOADER_NACK;
                        tx_valid <= 1'b1;
                        r_ack    <= 1'b0;
                        r_state  <= ST_RESP;
                     end
                  endcase
               end
            end

            ST_ADDR: begin
               if (rx_valid) begin
                  r_csum     <= r_csum ^ rx_data;
                  r_addr     <= {rx_data, r_addr[31:8]};
                  r_byte_cnt <= r_byte_cnt + 2'd1;
                  if (r_byte_cnt == 2'd3) begin
                     r_byte_cnt <= 2'd0;
                     r_state    <= ST_LEN;
                  end
               end
            end

            ST_LEN: begin
               if (rx_valid) begin
                  r_csum <= r_csum ^ rx_data;
                  if (r_byte_cnt == 2'd0) begin
                     r_len_lo   <= rx_data;
                     r_byte_cnt <= 2'd1;
                  end else begin
                     r_bad        <= range_bad(r_addr, w_len,
                                               w_is_dmem ? DMEM_ADDR_W : IMEM_ADDR_W);
                     r_words_left <= w_len;
                     r_waddr      <= r_addr[WA_W+1:2];
                     r_byte_cnt   <= 2'd0;
                     r_state      <= (w_len == 16'd0) ? ST_CSUM : ST_DATA;
                  end
               end
            end

            ST_DATA: begin
               if (rx_valid) begin
                  r_csum     <= r_csum ^ rx_data;
                  r_shift    <= {rx_data, r_shift[23:8]};
                  r_byte_cnt <= r_byte_cnt + 2'd1;
                  if (r_byte_cnt == 2'd3) begin
                     if (!r_bad && w_is_dmem) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= 1'b1;
                        dmem_be    <= 4'hF;
                        dmem_addr  <= r_waddr[DMEM_ADDR_W-1:0];
                        dmem_wdata <= w_word;
                     end else if (!r_bad) begin
                        imem_req   <= 1'b1;
                        imem_we    <= 1'b1;
                        imem_be    <= 4'hF;
                        imem_addr  <= r_waddr[IMEM_ADDR_W-1:0];
                        imem_wdata <= w_word;
                     end
                     r_waddr      <= r_waddr + WA_W'(1);
                     r_words_left <= r_words_left - 16'd1;
                     if (r_words_left == 16'd1) begin
                        r_state <= ST_CSUM;
                     end
                  end
               end
            end

            ST_CSUM: begin
               if (rx_valid) begin
                  tx_valid <= 1'b1;
                  r_state  <= ST_RESP;
                  if ((r_csum == rx_data) && !r_bad) begin
                     tx_data <= LOADER_ACK;
                     r_ack   <= 1'b1;
                  end else begin
                     tx_data <= LOADER_NACK;
                     r_ack   <= 1'b0;
                  end
               end
            end

            ST_RESP: begin
               if (tx_ready) begin
                  tx_valid <= 1'b0;
                  r_state  <= ST_IDLE;
                  if (r_ack && (r_cmd == LOADER_CMD_RUN)) begin
                     core_rst_n <= 1'b1;
                  end else if (r_ack && (r_cmd == LOADER_CMD_HALT)) begin
                     core_rst_n <= 1'b0;
                  end
               end
            end

            default: r_state <= ST_IDLE;
         endcase

         // Abandon the packet silently; only reachable when no byte arrived this cycle.
         if (w_expired) begin
            r_state     <= ST_IDLE;
            err_timeout <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pito_uart_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pito_uart_loader                                                  |
// | Scoreboard bench for the UART boot loader.                           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_pito_uart_loader;

   localparam int unsigned TMO = 300;

   logic        clk;
   logic        rst_n;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  tx_data;
   logic        imem_req, imem_we, dmem_req, dmem_we;
   logic [9:0]  imem_addr, dmem_addr;
   logic [31:0] imem_wdata, dmem_wdata;
   logic [3:0]  imem_be, dmem_be;
   logic        core_rst_n, busy, err_timeout;

   typedef struct {
      bit          dmem;
      int unsigned addr;
      logic [31:0] data;
   } wr_t;

   wr_t         exp_wr[$];
   logic [7:0]  exp_tx[$];
   logic [31:0] wq[$];
   int          checks = 0;
   int          errors = 0;
   wr_t         mon_e;
   logic [7:0]  mon_b;

   pito_uart_loader #(
      .IMEM_ADDR_W    (10),
      .DMEM_ADDR_W    (10),
      .TIMEOUT_CYCLES (TMO),
      .SYNC_BYTE      (8'hA5)
   ) dut (
      .clk (clk), .rst_n (rst_n),
      .rx_valid (rx_valid), .rx_data (rx_data),
      .tx_valid (tx_valid), .tx_ready (tx_ready), .tx_data (tx_data),
      .imem_req (imem_req), .imem_we (imem_we), .imem_addr (imem_addr),
      .imem_wdata (imem_wdata), .imem_be (imem_be),
      .dmem_req (dmem_req), .dmem_we (dmem_we), .dmem_addr (dmem_addr),
      .dmem_wdata (dmem_wdata), .dmem_be (dmem_be),
      .core_rst_n (core_rst_n), .busy (busy), .err_timeout (err_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard monitor: every write strobe and tx handshake must match the next expectation.
   always @(negedge clk) begin
      if (rst_n) begin
         if (imem_req || dmem_req) begin
            checks++;
            if (imem_req && dmem_req) begin
               errors++;
               $display("FAIL dual_req imem_req=1 dmem_req=1 required one");
            end else if (exp_wr.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write imem_req=%0b dmem_req=%0b required none",
                        imem_req, dmem_req);
            end else begin
               mon_e = exp_wr.pop_front();
               if ((dmem_req !== mon_e.dmem) ||
                   ((dmem_req ? dmem_addr : imem_addr) !== mon_e.addr[9:0]) ||
                   ((dmem_req ? dmem_wdata : imem_wdata) !== mon_e.data) ||
                   ((dmem_req ? dmem_we : imem_we) !== 1'b1) ||
                   ((dmem_req ? dmem_be : imem_be) !== 4'hF)) begin
                  errors++;
                  $display("FAIL write got dmem=%0b addr=%0d data=%h we=%0b be=%h required dmem=%0b addr=%0d data=%h we=1 be=f",
                           dmem_req, dmem_req ? dmem_addr : imem_addr,
                           dmem_req ? dmem_wdata : imem_wdata,
                           dmem_req ? dmem_we : imem_we, dmem_req ? dmem_be : imem_be,
                           mon_e.dmem, mon_e.addr, mon_e.data);
               end
            end
         end
         if (tx_valid && tx_ready) begin
            checks++;
            if (exp_tx.size() == 0) begin
               errors++;
               $display("FAIL unexpected_tx got %h required none", tx_data);
            end else begin
               mon_b = exp_tx.pop_front();
               if (tx_data !== mon_b) begin
                  errors++;
                  $display("FAIL tx_byte got %h required %h", tx_data, mon_b);
               end
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   // Sends a write packet carrying the words in wq; expectations follow the bench's own range rule.
   task automatic send_write(input bit dmem, input logic [31:0] addr, input bit corrupt);
      logic [7:0]  bytes[$];
      logic [7:0]  cs;
      logic [31:0] w;
      int unsigned n;
      bit          ok;
      n  = wq.size();
      ok = (addr[1:0] == 2'b00) && ((addr >> 2) + n <= 1024);
      bytes.push_back(dmem ? 8'h02 : 8'h01);
      for (int i = 0; i < 4; i++) bytes.push_back(addr[8*i +: 8]);
      bytes.push_back(n[7:0]);
      bytes.push_back(n[15:8]);
      for (int i = 0; i < n; i++) begin
         w = wq[i];
         for (int k = 0; k < 4; k++) bytes.push_back(w[8*k +: 8]);
         if (ok) exp_wr.push_back('{dmem, (addr >> 2) + i, w});
      end
      cs = 8'h00;
      foreach (bytes[i]) cs = cs ^ bytes[i];
      bytes.push_back(corrupt ? ~cs : cs);
      exp_tx.push_back((ok && !corrupt) ? 8'h06 : 8'h15);
      send_byte(8'hA5);
      foreach (bytes[i]) send_byte(bytes[i]);
   endtask

   task automatic wait_resp(input string name);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (exp_tx.size() == 0 && !tx_valid) begin
            done = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL %s_resp_timeout pending_tx=%0d required 0", name, exp_tx.size());
      end
      checks++;
      if (exp_wr.size() != 0) begin
         errors++;
         $display("FAIL %s_writes_missing pending=%0d required 0", name, exp_wr.size());
      end
      exp_wr.delete();
      exp_tx.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
      #22;
      checks++;
      if ({core_rst_n, tx_valid, busy, err_timeout, imem_req, dmem_req} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags got core=%0b txv=%0b busy=%0b err=%0b ireq=%0b dreq=%0b required all 0",
                  core_rst_n, tx_valid, busy, err_timeout, imem_req, dmem_req);
      end
      checks++;
      if ({imem_addr, imem_wdata, imem_be, dmem_addr, dmem_wdata, dmem_be, tx_data} !== '0) begin
         errors++;
         $display("FAIL reset_data got iaddr=%0d daddr=%0d tx=%h required zeros", imem_addr, dmem_addr, tx_data);
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_imem_write();
      wq = '{32'h44332211, 32'h88776655};
      send_write(1'b0, 32'h0, 1'b0);
      wait_resp("imem_write");
   endtask

   task automatic test_dmem_bad_csum();
      wq = '{32'hDEADBEEF};
      send_write(1'b1, 32'h10, 1'b1);
      wait_resp("dmem_bad_csum");
   endtask

   task automatic test_range();
      wq = '{32'h01020304};
      send_write(1'b0, 32'h2, 1'b0);
      wait_resp("misaligned");
      wq = '{32'hCAFE0001, 32'hCAFE0002};
      send_write(1'b0, 32'hFFC, 1'b0);
      wait_resp("overflow");
      wq = '{32'h11111111, 32'h22222222};
      send_write(1'b1, 32'hFF8, 1'b0);
      wait_resp("top_fit");
   endtask

   task automatic test_run_halt();
      bit seen;
      tx_ready = 1'b0;
      exp_tx.push_back(8'h06);
      send_byte(8'hA5); send_byte(8'h03); send_byte(8'h03);
      for (int i = 0; i < 20; i++) begin
         checks++;
         if (tx_valid !== 1'b1 || tx_data !== 8'h06 || core_rst_n !== 1'b0) begin
            errors++;
            $display("FAIL run_hold cyc=%0d got txv=%0b tx=%h core=%0b required 1 06 0",
                     i, tx_valid, tx_data, core_rst_n);
         end
         @(posedge clk);
         #1;
      end
      tx_ready = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (core_rst_n !== 1'b1 || tx_valid !== 1'b0) begin
         errors++;
         $display("FAIL run_release got core=%0b txv=%0b required 1 0", core_rst_n, tx_valid);
      end
      wait_resp("run");
      exp_tx.push_back(8'h06);
      send_byte(8'hA5); send_byte(8'h04); send_byte(8'h04);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (tx_valid && tx_ready) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      checks++;
      if (!seen || core_rst_n !== 1'b1) begin
         errors++;
         $display("FAIL halt_pre got seen=%0b core=%0b required 1 1", seen, core_rst_n);
      end
      @(posedge clk);
      #1;
      checks++;
      if (core_rst_n !== 1'b0) begin
         errors++;
         $display("FAIL halt_hold got core=%0b required 0", core_rst_n);
      end
      wait_resp("halt");
   endtask

   task automatic test_timeout();
      send_byte(8'hA5);
      send_byte(8'h01);
      repeat (TMO - 1) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b1 || err_timeout !== 1'b0) begin
         errors++;
         $display("FAIL timeout_early got busy=%0b err=%0b required 1 0", busy, err_timeout);
      end
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || err_timeout !== 1'b1 || tx_valid !== 1'b0) begin
         errors++;
         $display("FAIL timeout_fire got busy=%0b err=%0b txv=%0b required 0 1 0",
                  busy, err_timeout, tx_valid);
      end
      exp_tx.push_back(8'h15);
      send_byte(8'hA5);
      checks++;
      if (err_timeout !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL timeout_clear got err=%0b busy=%0b required 0 1", err_timeout, busy);
      end
      send_byte(8'h7F);
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h15) begin
         errors++;
         $display("FAIL unknown_cmd got txv=%0b tx=%h required 1 15", tx_valid, tx_data);
      end
      wait_resp("unknown_cmd");
   endtask

   task automatic test_back_to_back();
      wq = '{32'hA5A5A5A5, 32'h000000A5, 32'hA5000001};
      send_write(1'b1, 32'h20, 1'b0);
      wait_resp("sync_in_data");
      wq = '{32'h12345678};
      send_write(1'b0, 32'h0, 1'b0);
      wait_resp("b2b_imem");
      exp_tx.push_back(8'h06);
      send_byte(8'hA5); send_byte(8'h03); send_byte(8'h03);
      wait_resp("run2");
   endtask

   task automatic test_reset_mid();
      send_byte(8'hA5); send_byte(8'h01);
      send_byte(8'h40); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      send_byte(8'h03); send_byte(8'h00);
      send_byte(8'hDD); send_byte(8'hCC); send_byte(8'hBB); send_byte(8'hAA);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 10'd16 || imem_wdata !== 32'hAABBCCDD) begin
         errors++;
         $display("FAIL mid_req got req=%0b addr=%0d data=%h required 1 16 aabbccdd",
                  imem_req, imem_addr, imem_wdata);
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({imem_req, imem_we, imem_be, imem_addr, imem_wdata, busy, core_rst_n, tx_valid} !== '0) begin
         errors++;
         $display("FAIL async_reset got req=%0b addr=%0d data=%h busy=%0b core=%0b required zeros",
                  imem_req, imem_addr, imem_wdata, busy, core_rst_n);
      end
      #10 rst_n = 1'b1;
      @(posedge clk);
      #1;
      wq = '{32'h0BADF00D};
      send_write(1'b0, 32'h40, 1'b0);
      wait_resp("after_reset");
   endtask

   initial begin
      test_reset();
      test_imem_write();
      test_dmem_bad_csum();
      test_range();
      test_run_halt();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
